// File: rtl/spike_rate_encoder.sv
// spike_rate_encoder: first-order sigma-delta rate coder, NUM_CH intensities to 1-bit spike trains
// ports: clk, rst_n (async, active-low); in_valid/in_ready/in_data load one vector per window;
// step_en advances one timestep in RUN; abort cancels the window; spike_out/spike_valid carry
// the registered per-step result; step_count, busy and done report window progress
module spike_rate_encoder #(
  parameter int NUM_CH  = 8,
  parameter int VAL_W   = 8,
  parameter int WIN_LEN = 16,
  parameter int WIN_W   = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [NUM_CH*VAL_W-1:0] in_data,
  input  logic                    step_en,
  input  logic                    abort,
  output logic [NUM_CH-1:0]       spike_out,
  output logic                    spike_valid,
  output logic [WIN_W-1:0]        step_count,
  output logic                    busy,
  output logic                    done
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state_q, state_d;
  logic [NUM_CH-1:0][VAL_W-1:0] val_q, acc_q, acc_d;
  logic [NUM_CH-1:0] carry;
  logic accept, step, last;
  assign in_ready = state_q == IDLE;
  assign busy = state_q == RUN;
  assign done = state_q == DONE;
  // the accumulator carry-out is the spike; the wrapped sum is the residue kept for the next step
  always_comb begin
    accept = in_valid && in_ready && !abort;
    step = busy && step_en && !abort;
    last = step && step_count == WIN_W'(WIN_LEN - 1);
    state_d = abort ? IDLE : accept ? RUN : last ? DONE : done ? IDLE : state_q;
    for (int c = 0; c < NUM_CH; c++)
      {carry[c], acc_d[c]} = {1'b0, acc_q[c]} + {1'b0, val_q[c]};
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      val_q <= '0;
      acc_q <= '0;
      spike_out <= '0;
      spike_valid <= 1'b0;
      step_count <= '0;
    end else begin
      state_q <= state_d;
      spike_out <= '0;
      spike_valid <= 1'b0;
      if (abort) begin
        acc_q <= '0;
        step_count <= '0;
      end else if (accept) begin
        val_q <= in_data;
        acc_q <= '0;
        step_count <= '0;
      end else if (step) begin
        acc_q <= acc_d;
        spike_out <= carry;
        spike_valid <= 1'b1;
        step_count <= step_count + WIN_W'(1);
      end
    end
  end
endmodule

// File: tb/tb_spike_rate_encoder.sv
// tb_spike_rate_encoder: directed vector bench for spike_rate_encoder
module tb_spike_rate_encoder;
  logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, step_en = 1'b0, abort = 1'b0;
  logic [63:0] in_data = '0;
  logic in_ready, spike_valid, busy, done;
  logic [7:0] spike_out, step_count;
  int n_cmp = 0, n_err = 0;

  typedef struct {
    logic [63:0]     data;
    bit              tog;
    logic [7:0][7:0] cnt;
    int              cyc;
  } vec_t;
  vec_t v[5];

  spike_rate_encoder dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .step_en(step_en), .abort(abort), .spike_out(spike_out), .spike_valid(spike_valid),
    .step_count(step_count), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    n_cmp++;
    if (a !== e) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [63:0] d);
    for (int i = 0; i < 50 && !in_ready; i++) tick();
    chk("load_ready", in_ready, 1);
    in_valid = 1'b1;
    in_data = d;
    tick();
    in_valid = 1'b0;
    chk("load_busy", busy, 1);
  endtask

  task automatic run(input bit tog, output logic [7:0][7:0] cnt, output int cyc, output int sc);
    bit got = 0;
    logic pe;
    cnt = '0;
    cyc = 1;
    sc = 0;
    for (int i = 0; i < 100 && !got; i++) begin
      step_en = tog ? (i % 2 == 0) : 1'b1;
      pe = step_en;
      tick();
      cyc++;
      chk("valid_follows_step", spike_valid, pe);
      if (!spike_valid) chk("idle_spike_zero", spike_out, 0);
      else for (int c = 0; c < 8; c++) cnt[c] = cnt[c] + 8'(spike_out[c]);
      if (done) begin
        got = 1;
        sc = step_count;
      end
    end
    step_en = 1'b0;
    chk("window_done_seen", got, 1);
    tick();
    chk("post_done_ready", in_ready, 1);
    chk("post_done_pulse", done, 0);
  endtask

  initial begin
    logic [7:0][7:0] cnt;
    int cyc, sc;
    bit seen;
    v[0] = '{64'h80808080_80808080, 0, 64'h08080808_08080808, 17};
    v[1] = '{64'h00000000_4010FF00, 0, 64'h00000000_04010F00, 17};
    v[2] = '{64'hFFFFFFFF_FFFFFFFF, 1, 64'h0F0F0F0F_0F0F0F0F, 32};
    v[3] = '{64'h2008027F_C055F001, 0, 64'h02000007_0C050F00, 17};
    v[4] = '{64'hFFFFFFFF_FFFFFFFF, 0, 64'h0F0F0F0F_0F0F0F0F, 17};

    #2;
    chk("rst_spike", spike_out, 0);
    chk("rst_valid", spike_valid, 0);
    chk("rst_count", step_count, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    #4 rst_n = 1'b1;
    tick();
    chk("rst_ready", in_ready, 1);

    load(64'h80808080_80808080);
    for (int k = 1; k <= 16; k++) begin
      step_en = 1'b1;
      tick();
      chk("half_pattern", spike_out, (k % 2 == 0) ? 8'hFF : 8'h00);
      chk("half_count", step_count, k);
      chk("half_done", done, k == 16);
    end
    step_en = 1'b0;
    tick();
    chk("half_ready_after", in_ready, 1);

    foreach (v[j]) begin
      load(v[j].data);
      run(v[j].tog, cnt, cyc, sc);
      for (int c = 0; c < 8; c++) chk($sformatf("vec%0d_ch%0d_count", j, c), cnt[c], v[j].cnt[c]);
      chk($sformatf("vec%0d_cycles", j), cyc, v[j].cyc);
      chk($sformatf("vec%0d_step_count", j), sc, 16);
    end

    in_valid = 1'b1;
    in_data = 64'hFFFFFFFF_FFFFFFFF;
    tick();
    in_data = 64'h80808080_80808080;
    chk("hold_busy", busy, 1);
    seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      step_en = 1'b1;
      tick();
      chk("hold_no_accept", in_ready, 0);
      seen = done;
    end
    chk("hold_done_seen", seen, 1);
    tick();
    chk("hold_idle_ready", in_ready, 1);
    step_en = 1'b0;
    tick();
    in_valid = 1'b0;
    chk("hold_accept_busy", busy, 1);
    run(0, cnt, cyc, sc);
    chk("hold_fresh_acc", cnt, 64'h08080808_08080808);
    chk("hold_cycles", cyc, 17);

    load(64'h80808080_80808080);
    for (int k = 1; k <= 4; k++) begin
      step_en = 1'b1;
      tick();
    end
    chk("abort_pre_count", step_count, 4);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    step_en = 1'b0;
    chk("abort_spike", spike_out, 0);
    chk("abort_valid", spike_valid, 0);
    chk("abort_count", step_count, 0);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_ready", in_ready, 1);
    tick();
    chk("abort_no_late_done", done, 0);
    in_valid = 1'b1;
    abort = 1'b1;
    tick();
    in_valid = 1'b0;
    abort = 1'b0;
    chk("abort_idle_no_accept", busy, 0);

    load(64'hFFFFFFFF_FFFFFFFF);
    for (int k = 1; k <= 8; k++) begin
      step_en = 1'b1;
      tick();
    end
    chk("rst_mid_pre_count", step_count, 8);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_spike", spike_out, 0);
    chk("rst_mid_valid", spike_valid, 0);
    chk("rst_mid_count", step_count, 0);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_done", done, 0);
    step_en = 1'b0;
    #1 rst_n = 1'b1;
    tick();
    chk("rst_mid_ready", in_ready, 1);
    load(64'hC0C0C0C0_C0C0C0C0);
    run(0, cnt, cyc, sc);
    chk("rst_mid_new_counts", cnt, 64'h0C0C0C0C_0C0C0C0C);
    chk("rst_mid_new_cycles", cyc, 17);
    chk("rst_mid_new_steps", sc, 16);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/spike_rate_encoder.md
Name: spike_rate_encoder

Overview:
- Rate-codes NUM_CH unsigned intensity values into per-channel 1-bit spike trains.
- Uses one first-order sigma-delta accumulator per channel, run over an encoding window of WIN_LEN timesteps.
- Sits upstream of the LIF network: spike_out drives the network's per-neuron current inputs directly.
- An upstream controller loads one intensity vector per window through a valid/ready handshake.

Parameters:
- NUM_CH, 8: number of channels; equals the number of first-layer LIF neurons.
- VAL_W, 8: intensity width per channel; also the accumulator width.
- WIN_LEN, 16: timesteps per encoding window; legal range 1 .. 2^WIN_W-1.
- WIN_W, 8: width of step_count.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  reset; asynchronous, active-low.
- in_valid  input  1  intensity vector on in_data is valid.
- in_ready  output  1  encoder can accept a vector; high only in IDLE.
- in_data  input  NUM_CH*VAL_W  channel c occupies bits [c*VAL_W +: VAL_W].
- step_en  input  1  advance one timestep in this cycle (RUN only).
- abort  input  1  synchronous window cancel.
- spike_out  output  NUM_CH  registered spike vector; bit c is channel c.
- spike_valid  output  1  spike_out holds a timestep result this cycle.
- step_count  output  WIN_W  number of timesteps completed in the current window.
- busy  output  1  high in RUN.
- done  output  1  one-cycle pulse when a window completes.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=IDLE.
  - Value registers and accumulators = 0.
  - spike_out=0, spike_valid=0, step_count=0, busy=0, done=0.
  - in_ready=1 once reset is released.
- States: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready: latch in_data into value registers, clear all accumulators, step_count=0, go to RUN next cycle.
  - in_data is don't-care when in_valid=0.
- RUN:
  - in_ready=0, busy=1.
  - On a cycle with step_en=1, for each channel c: sum = acc[c] + val[c], computed at VAL_W+1 bits.
  - spike_out[c] <= sum[VAL_W] (the carry); acc[c] <= sum[VAL_W-1:0].
  - spike_valid <= 1; step_count <= step_count+1.
  - Latency: step at edge t, result visible after edge t+1. The first step may occur in the cycle immediately after acceptance.
  - Cycles with step_en=0: spike_out <= 0, spike_valid <= 0. Accumulators and step_count hold. The network sees zero current on idle cycles.
  - The step that makes step_count == WIN_LEN transitions to DONE. That final step's spikes are emitted normally.
- DONE:
  - Held for exactly one cycle: done=1, spike_out <= 0, spike_valid <= 0, in_ready=0.
  - Next state is IDLE.
  - step_count holds WIN_LEN until the next acceptance.
  - in_valid asserted during DONE is not accepted and must be held by the source.
- Spike-count rule: with acc cleared at load, channel c emits exactly floor(val[c]*WIN_LEN / 2^VAL_W) spikes per window.
  - val=0 never spikes.
  - Spikes are evenly spaced, with no burst longer than one for val < 2^(VAL_W-1).
- abort:
  - Highest priority in any state: next state is IDLE; spike_out, spike_valid, done, busy, accumulators and step_count are cleared.
  - abort with step_en in the same cycle: abort wins and no spike is emitted.
  - abort in IDLE with in_valid: no acceptance that cycle.
- step_en is ignored in IDLE and DONE.
- Asynchronous reset mid-window discards the window. No partial done pulse is produced.

Test Plan:
- Reset, then load all channels = 0x80 (WIN_LEN=16, step_en tied high). Each channel emits spikes on steps 2, 4, …, 16 (8 spikes per channel). spike_out=0xFF on even steps and 0x00 on odd steps. done pulses 1 cycle after step 16. in_ready returns 1 on the following cycle.
- Load ch0=0x00, ch1=0xFF, ch2=0x10, ch3=0x40, others=0x00. Per-window spike counts must be 0, 15, 1, 4, 0, 0, 0, 0. step_count must read 16 at done.
- Toggle step_en 1,0,1,0 during RUN with all channels = 0xFF. spike_valid follows step_en delayed by 1 cycle. spike_out=0 on non-step cycles. The window takes 32 cycles. Totals match the continuous run.
- Hold in_valid high across a full window with new data. No acceptance while busy or done. Acceptance happens in the first IDLE cycle. Accumulators start from 0 with no carry-over from the previous window.
- Assert abort together with step_en at step 5. No spike is emitted that cycle. Next cycle: state IDLE, step_count=0, busy=0, no done pulse.
- Drop rst_n asynchronously mid-clock at step 9. All outputs go to reset values immediately, with no clock edge needed. After release, in_ready=1 and a new load runs a full 16-step window.
